// File: rtl/button_led_pkg.sv
// Shared types and constants for the button front end and LED pattern engine.
// Key indices 0..2 carry the pattern control functions.
package button_led_pkg;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_OFF    = 2'd3
    } led_mode_t;

    localparam int KEY_CLEAR = 0;
    localparam int KEY_UP    = 1;
    localparam int KEY_DOWN  = 2;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/button_led_controller_key_debounce.sv
// Single-key front end: 2-flop synchroniser, debounce counter, accepted level
// and a one-cycle pulse on each accepted press (never on release).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_pressed,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             pulse_q, pulse_d;
    logic             level_pressed;

    assign level_pressed = ~sync_q[1];

    // The counter only survives while the synchronised level disagrees with
    // the accepted one, so any agreeing sample restarts qualification.
    always_comb begin
        sync_d    = {sync_q[0], key_n};
        cnt_d     = '0;
        pressed_d = pressed_q;
        pulse_d   = 1'b0;
        if (level_pressed != pressed_q) begin
            if (cnt_q == CNT_MAX) begin
                pressed_d = ~pressed_q;
                pulse_d   = ~pressed_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            pulse_q   <= pulse_d;
        end
    end

    assign key_pressed = pressed_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/button_led_controller.sv
// Multi-key debounced button front end driving a mirror / chase / count LED
// pattern engine with runtime mode selection.
module button_led_controller
    import button_led_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_LEDS        = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [1:0]          mode,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_LEDS-1:0] led
);

    localparam int MIRROR_W = min_int(NUM_KEYS, NUM_LEDS);
    localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);

    led_mode_t           mode_sel;
    logic [NUM_LEDS-1:0] chase_q, chase_d;
    logic [NUM_LEDS-1:0] count_q, count_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] mirror_leds;

    assign mode_sel = led_mode_t'(mode);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk        (clk),
            .rst        (rst),
            .key_n      (key_n[g]),
            .key_pressed(key_pressed[g]),
            .press_pulse(press_pulse[g])
        );
    end

    always_comb begin
        mirror_leds               = '0;
        mirror_leds[MIRROR_W-1:0] = key_pressed[MIRROR_W-1:0];
    end

    // LEDs show the post-update pattern value so they move one cycle after
    // the press pulse; each pattern register only moves in its own mode.
    always_comb begin
        chase_d = chase_q;
        count_d = count_q;
        led_d   = '0;
        case (mode_sel)
            MODE_MIRROR: led_d = mirror_leds;
            MODE_CHASE: begin
                if (press_pulse[KEY_CLEAR]) begin
                    chase_d = LED_ONE;
                end else if (press_pulse[KEY_UP]) begin
                    chase_d = {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
                end else if (press_pulse[KEY_DOWN]) begin
                    chase_d = {chase_q[0], chase_q[NUM_LEDS-1:1]};
                end
                led_d = chase_d;
            end
            MODE_COUNT: begin
                if (press_pulse[KEY_CLEAR]) begin
                    count_d = '0;
                end else if (press_pulse[KEY_UP]) begin
                    count_d = count_q + LED_ONE;
                end else if (press_pulse[KEY_DOWN]) begin
                    count_d = count_q - LED_ONE;
                end
                led_d = count_d;
            end
            MODE_OFF: led_d = '0;
            default:  led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chase_q <= LED_ONE;
            count_q <= '0;
            led_q   <= '0;
        end else begin
            chase_q <= chase_d;
            count_q <= count_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_button_led_controller.sv
// Scoreboard bench for button_led_controller: a history-window reference model
// pushes expected outputs each edge and a negedge monitor compares them.
module tb_button_led_controller;
    import button_led_pkg::*;

    localparam int NUM_KEYS = 4;
    localparam int NUM_LEDS = 10;
    localparam int DEB      = 4;
    localparam int MAX_HIST = 16;

    typedef struct packed {
        logic [NUM_KEYS-1:0] kp;
        logic [NUM_KEYS-1:0] pp;
        logic [NUM_LEDS-1:0] led;
    } exp_t;

    logic                clk;
    logic                rst;
    logic [NUM_KEYS-1:0] key_n;
    logic [1:0]          mode;
    logic [NUM_KEYS-1:0] key_pressed;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_LEDS-1:0] led;

    int tests_run = 0;
    int failures  = 0;

    exp_t                exp_q[$];
    logic [NUM_KEYS-1:0] raw_hist[$];
    logic [NUM_KEYS-1:0] m_pressed;
    logic [NUM_KEYS-1:0] m_pulse;
    logic [NUM_LEDS-1:0] m_led;
    int                  m_pos;
    int                  m_count;

    button_led_controller #(
        .NUM_KEYS       (NUM_KEYS),
        .NUM_LEDS       (NUM_LEDS),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .mode       (mode),
        .key_pressed(key_pressed),
        .press_pulse(press_pulse),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_KEYS-1:0] kn, input logic [1:0] md,
                                 input int cycles);
        key_n = kn;
        mode  = md;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pressKey(input int k, input logic [1:0] md);
        logic [NUM_KEYS-1:0] kn;
        kn    = '1;
        kn[k] = 1'b0;
        applyStimulus(kn, md, 8);
        applyStimulus('1, md, 8);
    endtask

    // Reference model: a key is accepted once the last DEB samples seen two
    // edges late all disagree with the accepted level; patterns use plain
    // modular arithmetic on a position index and an integer count.
    always @(posedge clk) begin
        exp_t e;
        int   sz;
        bit   all_diff;
        logic s;
        if (rst) begin
            raw_hist = {};
            raw_hist.push_back('1);
            raw_hist.push_back('1);
            m_pressed = '0;
            m_pulse   = '0;
            m_pos     = 0;
            m_count   = 0;
            m_led     = '0;
        end else begin
            m_led = '0;
            case (mode)
                2'd0: begin
                    for (int i = 0; i < NUM_KEYS && i < NUM_LEDS; i++) m_led[i] = m_pressed[i];
                end
                2'd1: begin
                    if (m_pulse[0])      m_pos = 0;
                    else if (m_pulse[1]) m_pos = (m_pos + 1) % NUM_LEDS;
                    else if (m_pulse[2]) m_pos = (m_pos + NUM_LEDS - 1) % NUM_LEDS;
                    m_led[m_pos] = 1'b1;
                end
                2'd2: begin
                    if (m_pulse[0])      m_count = 0;
                    else if (m_pulse[1]) m_count = (m_count + 1) % (1 << NUM_LEDS);
                    else if (m_pulse[2]) m_count = (m_count + (1 << NUM_LEDS) - 1) % (1 << NUM_LEDS);
                    m_led = NUM_LEDS'(m_count);
                end
                default: m_led = '0;
            endcase

            raw_hist.push_back(key_n);
            if (raw_hist.size() > MAX_HIST) void'(raw_hist.pop_front());
            sz      = raw_hist.size();
            m_pulse = '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (sz >= DEB + 2) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < DEB; j++) begin
                        s = raw_hist[sz - 3 - j][k];
                        if ((!s) == m_pressed[k]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        m_pressed[k] = ~m_pressed[k];
                        m_pulse[k]   = m_pressed[k];
                    end
                end
            end
        end
        e.kp  = m_pressed;
        e.pp  = m_pulse;
        e.led = m_led;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("key_pressed", 16'(key_pressed), 16'(e.kp));
            checkOutput("press_pulse", 16'(press_pulse), 16'(e.pp));
            checkOutput("led", 16'(led), 16'(e.led));
        end
    end

    initial begin
        logic [NUM_LEDS-1:0] onehot;
        bit                  seen;
        int                  first_pulse;
        int                  dur;

        rst   = 1'b1;
        key_n = '1;
        mode  = MODE_MIRROR;
        repeat (3) @(negedge clk);
        checkOutput("reset_kp", 16'(key_pressed), 16'h0);
        checkOutput("reset_pp", 16'(press_pulse), 16'h0);
        checkOutput("reset_led", 16'(led), 16'h0);
        rst = 1'b0;
        applyStimulus('1, MODE_MIRROR, 1);
        checkOutput("post_reset_led", 16'(led), 16'h0);

        applyStimulus(4'b1110, MODE_MIRROR, 5);
        checkOutput("latency_early_kp0", 16'(key_pressed[0]), 16'h0);
        applyStimulus(4'b1110, MODE_MIRROR, 1);
        checkOutput("latency_kp0", 16'(key_pressed[0]), 16'h1);
        checkOutput("latency_pp0", 16'(press_pulse[0]), 16'h1);
        checkOutput("latency_led_lag", 16'(led), 16'h0);
        applyStimulus(4'b1110, MODE_MIRROR, 1);
        checkOutput("pulse_width_pp0", 16'(press_pulse[0]), 16'h0);
        checkOutput("mirror_led", 16'(led), 16'h001);
        applyStimulus(4'b1110, MODE_MIRROR, 3);
        applyStimulus('1, MODE_MIRROR, 8);
        checkOutput("release_led", 16'(led), 16'h000);

        seen = 1'b0;
        for (int c = 0; c < 17; c++) begin
            key_n    = '1;
            key_n[1] = (c < 3 || (c >= 4 && c < 7)) ? 1'b0 : 1'b1;
            @(negedge clk);
            seen = seen | key_pressed[1] | press_pulse[1];
        end
        checkOutput("bounce_rejected", 16'(seen), 16'h0);

        applyStimulus('1, MODE_CHASE, 2);
        checkOutput("chase_initial", 16'(led), 16'h001);
        for (int i = 0; i < NUM_LEDS; i++) begin
            pressKey(KEY_UP, MODE_CHASE);
            onehot = '0;
            onehot[(i + 1) % NUM_LEDS] = 1'b1;
            checkOutput("chase_up", 16'(led), 16'(onehot));
        end
        pressKey(KEY_DOWN, MODE_CHASE);
        checkOutput("chase_down_wrap", 16'(led), 16'h200);

        applyStimulus('1, MODE_COUNT, 2);
        checkOutput("count_initial", 16'(led), 16'h000);
        pressKey(KEY_DOWN, MODE_COUNT);
        checkOutput("count_down_wrap", 16'(led), 16'h3FF);
        pressKey(KEY_UP, MODE_COUNT);
        checkOutput("count_up_wrap", 16'(led), 16'h000);
        applyStimulus(4'b1100, MODE_COUNT, 8);
        applyStimulus('1, MODE_COUNT, 8);
        checkOutput("count_priority", 16'(led), 16'h000);

        applyStimulus('1, MODE_CHASE, 2);
        pressKey(KEY_CLEAR, MODE_CHASE);
        repeat (3) pressKey(KEY_UP, MODE_CHASE);
        checkOutput("chase_bit3", 16'(led), 16'h008);
        applyStimulus('1, MODE_COUNT, 2);
        repeat (2) pressKey(KEY_UP, MODE_COUNT);
        checkOutput("count_two", 16'(led), 16'h002);
        applyStimulus('1, MODE_CHASE, 2);
        checkOutput("chase_persist", 16'(led), 16'h008);
        applyStimulus('1, MODE_OFF, 2);
        checkOutput("off_led", 16'(led), 16'h000);
        applyStimulus('1, MODE_COUNT, 2);
        checkOutput("count_persist", 16'(led), 16'h002);

        applyStimulus(4'b1110, MODE_MIRROR, 2);
        rst = 1'b1;
        applyStimulus(4'b1110, MODE_MIRROR, 1);
        checkOutput("mid_reset_kp", 16'(key_pressed), 16'h0);
        rst = 1'b0;
        first_pulse = 0;
        for (int n = 1; n <= 20; n++) begin
            applyStimulus(4'b1110, MODE_MIRROR, 1);
            if (press_pulse[0] && first_pulse == 0) first_pulse = n;
        end
        checkOutput("requalify_cycles", 16'(first_pulse), 16'd6);
        applyStimulus('1, MODE_MIRROR, 8);

        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                applyStimulus(key_n, mode, 1);
                rst = 1'b0;
            end
            dur = $urandom_range(1, 10);
            applyStimulus(NUM_KEYS'($urandom), mode, dur);
        end
        applyStimulus('1, MODE_MIRROR, 12);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
